// File: rtl/ch_pkg.sv
//------------------------------------------------------------------------------
// Module   : ch_pkg
// Purpose  : Shared constants, FSM states and status codes for the CH table.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ch_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 32;
    localparam int IDX_W      = 5;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STAT_NONE  = 2'd0,
        STAT_WROTE = 2'd1,
        STAT_DUP   = 2'd2,
        STAT_OVF   = 2'd3
    } status_e;

endpackage

`default_nettype wire

// File: rtl/ch_table_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ch_table_ctrl
// Purpose  : Dedup-and-append write controller for the 32x16 cluster-head bank.
//            Optional host read port enabled by macro CH_RDPORT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ch_table_ctrl
    import ch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_node_id,
    input  logic                  clr,
    output logic                  mem_wr_en,
    output logic [IDX_W-1:0]      mem_index,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic [CNT_W-1:0]      ch_count,
    output logic                  full,
    output logic                  done,
    output logic                  wrote,
    output logic                  dup_hit,
    output logic                  overflow
`ifdef CH_RDPORT_EN
    ,
    input  logic                  rd_req,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid
`endif
);

    state_e                state_q, state_d;
    status_e               status_q, status_d;
    logic [WORD_WIDTH-1:0] id_q, id_d;
    logic [CNT_W-1:0]      ch_count_q, ch_count_d;
    logic [IDX_W-1:0]      mem_index_q, mem_index_d;
    logic [WORD_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  in_ready_q, in_ready_d;
    logic                  iss_v_q, iss_v_d;
    logic                  cmp_v_q, cmp_v_d;
    logic                  cmp_last_q, cmp_last_d;
    logic                  w_rd_sel;
    logic                  w_accept;
    logic                  w_full;

`ifdef CH_RDPORT_EN
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;

    assign w_rd_sel = (state_q == IDLE) && rd_req && !clr;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    assign w_rd_sel = 1'b0;
`endif

    assign w_full      = (ch_count_q == CNT_W'(MEM_DEPTH));
    assign in_ready    = in_ready_q && !clr && !w_rd_sel;
    assign w_accept    = in_valid && in_ready;
    assign mem_wr_en   = mem_wr_en_q && !clr;
`ifdef CH_RDPORT_EN
    assign mem_index   = w_rd_sel ? rd_index : mem_index_q;
`else
    assign mem_index   = mem_index_q;
`endif
    assign mem_data_in = mem_data_in_q;
    assign ch_count    = ch_count_q;
    assign full        = w_full;
    assign done        = (status_q != STAT_NONE);
    assign wrote       = (status_q == STAT_WROTE);
    assign dup_hit     = (status_q == STAT_DUP);
    assign overflow    = (status_q == STAT_OVF);

    always_comb begin
        state_d       = state_q;
        status_d      = STAT_NONE;
        id_d          = id_q;
        ch_count_d    = ch_count_q;
        mem_index_d   = mem_index_q;
        mem_data_in_d = mem_data_in_q;
        mem_wr_en_d   = 1'b0;
        iss_v_d       = 1'b0;
        cmp_v_d       = 1'b0;
        cmp_last_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    id_d = in_node_id;
                    if (ch_count_q == '0) begin
                        state_d       = WRITE;
                        mem_wr_en_d   = 1'b1;
                        mem_index_d   = '0;
                        mem_data_in_d = in_node_id;
                    end else if (w_full) begin
                        state_d  = DONE;
                        status_d = STAT_OVF;
                    end else begin
                        state_d     = SCAN;
                        mem_index_d = '0;
                        iss_v_d     = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Compare stage trails the issued index by the bank's read latency.
                cmp_v_d    = iss_v_q;
                cmp_last_d = iss_v_q && ({1'b0, mem_index_q} == ch_count_q - CNT_W'(1));
                iss_v_d    = iss_v_q && (({1'b0, mem_index_q} + CNT_W'(1)) < ch_count_q);
                if (iss_v_q) begin
                    mem_index_d = mem_index_q + IDX_W'(1);
                end
                if (cmp_v_q && (mem_data_out == id_q)) begin
                    state_d  = DONE;
                    status_d = STAT_DUP;
                    cmp_v_d  = 1'b0;
                    iss_v_d  = 1'b0;
                end else if (cmp_v_q && cmp_last_q) begin
                    state_d       = WRITE;
                    mem_wr_en_d   = 1'b1;
                    mem_index_d   = ch_count_q[IDX_W-1:0];
                    mem_data_in_d = id_q;
                    cmp_v_d       = 1'b0;
                    iss_v_d       = 1'b0;
                end
            end
            WRITE: begin
                state_d  = DONE;
                status_d = STAT_WROTE;
                if (!w_full) begin
                    ch_count_d = ch_count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            state_d     = IDLE;
            status_d    = STAT_NONE;
            ch_count_d  = '0;
            mem_wr_en_d = 1'b0;
            iss_v_d     = 1'b0;
            cmp_v_d     = 1'b0;
            cmp_last_d  = 1'b0;
        end

        in_ready_d = (state_d == IDLE);
    end

`ifdef CH_RDPORT_EN
    always_comb begin
        rd_pend_d  = w_rd_sel;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? mem_data_out : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            status_q      <= STAT_NONE;
            id_q          <= '0;
            ch_count_q    <= '0;
            mem_index_q   <= '0;
            mem_data_in_q <= '0;
            mem_wr_en_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            iss_v_q       <= 1'b0;
            cmp_v_q       <= 1'b0;
            cmp_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            id_q          <= id_d;
            ch_count_q    <= ch_count_d;
            mem_index_q   <= mem_index_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_en_q   <= mem_wr_en_d;
            in_ready_q    <= in_ready_d;
            iss_v_q       <= iss_v_d;
            cmp_v_q       <= cmp_v_d;
            cmp_last_q    <= cmp_last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ch_table_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ch_table_ctrl
// Purpose  : Self-checking bench for ch_table_ctrl with a behavioural bank.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ch_table_ctrl;
    import ch_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_node_id;
    logic                  clr;
    logic                  mem_wr_en;
    logic [IDX_W-1:0]      mem_index;
    logic [WORD_WIDTH-1:0] mem_data_in;
    logic [WORD_WIDTH-1:0] mem_data_out;
    logic [CNT_W-1:0]      ch_count;
    logic                  full;
    logic                  done;
    logic                  wrote;
    logic                  dup_hit;
    logic                  overflow;
`ifdef CH_RDPORT_EN
    logic                  rd_req;
    logic [IDX_W-1:0]      rd_index;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
`endif

    int tests = 0;
    int fails = 0;
    logic [WORD_WIDTH-1:0] tbl[$];
    logic [WORD_WIDTH-1:0] bank [0:MEM_DEPTH-1];

    ch_table_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_node_id   (in_node_id),
        .clr          (clr),
        .mem_wr_en    (mem_wr_en),
        .mem_index    (mem_index),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .ch_count     (ch_count),
        .full         (full),
        .done         (done),
        .wrote        (wrote),
        .dup_hit      (dup_hit),
        .overflow     (overflow)
`ifdef CH_RDPORT_EN
        ,
        .rd_req       (rd_req),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
`endif
    );

    // Bank with one-cycle registered read
    always @(posedge clk) begin
        if (mem_wr_en) bank[mem_index] <= mem_data_in;
        mem_data_out <= bank[mem_index];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Reference: result and latency derived from table contents alone
    task automatic do_req(input logic [WORD_WIDTH-1:0] id);
        int n, m, lat, kind, c, done_c, wr_n, wr_c;
        logic [31:0] wr_idx, wr_dat;
        logic f_w, f_d, f_o;
        n = tbl.size();
        m = -1;
        for (int i = 0; i < n; i++) if (m < 0 && tbl[i] == id) m = i;
        if (n == 0)              begin kind = 0; lat = 2;     end
        else if (n == MEM_DEPTH) begin kind = 2; lat = 1;     end
        else if (m >= 0)         begin kind = 1; lat = m + 3; end
        else                     begin kind = 0; lat = n + 3; end

        wait_ready();
        in_valid   = 1'b1;
        in_node_id = id;
        @(negedge clk);
        in_valid = 1'b0;
        done_c = -1; wr_n = 0; wr_c = -1; wr_idx = 0; wr_dat = 0;
        f_w = 1'b0; f_d = 1'b0; f_o = 1'b0;
        for (c = 1; c <= 40 && done_c < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_wr_en === 1'b1) begin
                wr_n++;
                wr_c   = c;
                wr_idx = 32'(mem_index);
                wr_dat = 32'(mem_data_in);
            end
            if (done === 1'b1) begin
                done_c = c;
                f_w = wrote; f_d = dup_hit; f_o = overflow;
            end
        end
        chk("latency",  done_c, lat);
        chk("wrote",    f_w, kind == 0);
        chk("dup_hit",  f_d, kind == 1);
        chk("overflow", f_o, kind == 2);
        chk("wr_count", wr_n, kind == 0);
        if (kind == 0) begin
            chk("wr_index", wr_idx, n);
            chk("wr_data",  wr_dat, 32'(id));
            chk("wr_cycle", wr_c, lat - 1);
            tbl.push_back(id);
        end
        chk("ch_count", 32'(ch_count), tbl.size());
        chk("full",     full, tbl.size() == MEM_DEPTH);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_node_id = '0; clr = 1'b0;
`ifdef CH_RDPORT_EN
        rd_req = 1'b0; rd_index = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",    in_ready, 1'b1);
        chk("rst_count",    32'(ch_count), 0);
        chk("rst_full",     full, 1'b0);
        chk("rst_done",     done, 1'b0);
        chk("rst_wr_en",    mem_wr_en, 1'b0);
        chk("rst_index",    32'(mem_index), 0);
        chk("rst_data_in",  32'(mem_data_in), 0);
        chk("rst_status",   {wrote, dup_hit, overflow}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        do_req(16'd87);
        do_req(16'd15);
        do_req(16'd23);
        do_req(16'd15);

`ifdef CH_RDPORT_EN
        rd_req = 1'b1; rd_index = 5'd1;
        chk("rd_mem_index", 32'(mem_index), 1);
        chk("rd_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_valid_early", rd_valid, 1'b0);
        @(negedge clk);
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_data",  32'(rd_data), 15);
        @(negedge clk);
        chk("rd_valid_pulse", rd_valid, 1'b0);
`endif

        for (int k = 0; k < 16; k++) do_req(16'($urandom_range(0, 9)));

        // Flush, fill to capacity, then overflow
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tbl.delete();
        chk("clr_count", 32'(ch_count), 0);
        for (int v = 100; v < 132; v++) do_req(16'(v));
        chk("full_set", full, 1'b1);
        do_req(16'd200);
        do_req(16'd131);

        // clr during second SCAN cycle aborts the request
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tbl.delete();
        do_req(16'd1);
        do_req(16'd2);
        wait_ready();
        in_valid = 1'b1; in_node_id = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tbl.delete();
        begin
            int seen_done, seen_wr;
            seen_done = 0; seen_wr = 0;
            for (int c = 0; c < 6; c++) begin
                if (done === 1'b1) seen_done++;
                if (mem_wr_en === 1'b1) seen_wr++;
                @(negedge clk);
            end
            chk("clr_no_done",  seen_done, 0);
            chk("clr_no_write", seen_wr, 0);
        end
        chk("clr_scan_count", 32'(ch_count), 0);
        chk("clr_scan_ready", in_ready, 1'b1);
        do_req(16'd5);

        // rst during WRITE: scan of 1 entry, WRITE in cycle 3
        wait_ready();
        in_valid = 1'b1; in_node_id = 16'd77;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_wr_en", mem_wr_en, 1'b1);
        chk("pre_rst_index", 32'(mem_index), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_wr_en", mem_wr_en, 1'b0);
        chk("rst_async_count", 32'(ch_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tbl.delete();
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_done",  done, 1'b0);
        do_req(16'd0);
        do_req(16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
